// File: rtl/alu_seq_if.sv
// Command-side bus of the ALU sequencer: start/done handshake, operands and
// the registered result/flags returned to the requester.
interface alu_seq_if #(
   parameter int DWIDTH = 16
);
   logic              start;
   logic [1:0]        cmd;
   logic [2:0]        op;
   logic [DWIDTH-1:0] a;
   logic [DWIDTH-1:0] b;
   logic              busy;
   logic              done;
   logic [DWIDTH-1:0] result;
   logic [3:0]        flags;

   modport master (
      output start, cmd, op, a, b,
      input  busy, done, result, flags
   );

   modport slave (
      input  start, cmd, op, a, b,
      output busy, done, result, flags
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle sequencer wrapped around a shared single-cycle ALU.
// Runs shift-by-N, shift-add multiply and single ALU ops, one ALU pass per
// RUN cycle, and owns the architectural {N,Z,C,V} flags fed back to the ALU.
module alu_seq #(
   parameter int DWIDTH = 16,
   parameter int SWIDTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   alu_seq_if.slave          bus,
   output logic [3:0]        alu_op,
   output logic [DWIDTH-1:0] alu_a,
   output logic [DWIDTH-1:0] alu_b,
   output logic [3:0]        alu_flags,
   input  logic [DWIDTH-1:0] alu_r,
   input  logic [3:0]        alu_fo
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] CMD_SHL = 2'b00;
   localparam logic [1:0] CMD_SHR = 2'b01;
   localparam logic [1:0] CMD_MUL = 2'b10;

   // Count must hold DWIDTH itself (multiply iterations), hence one extra bit.
   localparam int CWIDTH = SWIDTH + 1;

   logic [1:0]        state_reg;
   logic [1:0]        cmd_reg;
   logic [2:0]        op_reg;
   logic [DWIDTH-1:0] acc_reg;
   logic [DWIDTH-1:0] m_reg;
   logic [DWIDTH-1:0] q_reg;
   logic [CWIDTH-1:0] count_reg;
   logic [DWIDTH-1:0] result_reg;
   logic [3:0]        flags_reg;

   logic              accept;
   logic [CWIDTH-1:0] start_count;

   // A new command is taken only when idle or in the single DONE cycle.
   assign accept = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   assign bus.busy   = (state_reg == ST_RUN);
   assign bus.done   = (state_reg == ST_DONE);
   assign bus.result = result_reg;
   assign bus.flags  = flags_reg;
   assign alu_flags  = flags_reg;

   // Number of RUN cycles the incoming command needs (0 only for a zero shift).
   always_comb begin
      start_count = CWIDTH'(1);
      case (bus.cmd)
         CMD_SHL, CMD_SHR: start_count = CWIDTH'(bus.b[SWIDTH-1:0]);
         CMD_MUL:          start_count = CWIDTH'(DWIDTH);
         default:          start_count = CWIDTH'(1);
      endcase
   end

   // ALU drive: a harmless MOV of zero whenever not in RUN.
   always_comb begin
      alu_op = 4'b0000;
      alu_a  = '0;
      alu_b  = '0;
      if (state_reg == ST_RUN) begin
         case (cmd_reg)
            CMD_SHL: begin
               alu_op = 4'b0110;
               alu_b  = acc_reg;
            end
            CMD_SHR: begin
               alu_op = 4'b0111;
               alu_b  = acc_reg;
            end
            CMD_MUL: begin
               // MOV passes adata through, so a zero multiplier bit keeps acc.
               alu_op = q_reg[0] ? 4'b0100 : 4'b0000;
               alu_a  = acc_reg;
               alu_b  = m_reg;
            end
            default: begin
               alu_op = {1'b0, op_reg};
               alu_a  = acc_reg;
               alu_b  = m_reg;
            end
         endcase
      end
   end

   // Sequencer FSM and datapath; reset aborts any command without a done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cmd_reg    <= '0;
         op_reg     <= '0;
         acc_reg    <= '0;
         m_reg      <= '0;
         q_reg      <= '0;
         count_reg  <= '0;
         result_reg <= '0;
         flags_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  cmd_reg   <= bus.cmd;
                  op_reg    <= bus.op;
                  count_reg <= start_count;
                  // Single op reuses acc/m as its A/B operand holders.
                  acc_reg   <= (bus.cmd == CMD_MUL) ? '0 : bus.a;
                  m_reg     <= (bus.cmd == CMD_MUL) ? bus.a : bus.b;
                  q_reg     <= bus.b;
                  if (start_count == '0) begin
                     state_reg  <= ST_DONE;
                     result_reg <= bus.a;
                  end else begin
                     state_reg <= ST_RUN;
                  end
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc_reg   <= alu_r;
               m_reg     <= m_reg << 1;
               q_reg     <= q_reg >> 1;
               count_reg <= count_reg - CWIDTH'(1);
               // Multiply discards the per-step ALU flags.
               if (cmd_reg != CMD_MUL) begin
                  flags_reg <= alu_fo;
               end
               if (count_reg == CWIDTH'(1)) begin
                  state_reg  <= ST_DONE;
                  result_reg <= alu_r;
                  if (cmd_reg == CMD_MUL) begin
                     flags_reg <= {alu_r[DWIDTH-1], (alu_r == '0), flags_reg[1:0]};
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
